axi_single_beat_bridge: RTL and testbench

- Converts the one-word request/accept/fin handshake from the uncached access unit into single-beat AXI4 read or write transactions.
- Sits between the uncache unit and the SoC AXI interconnect.
- One outstanding transaction at a time; no bursts, no reordering.

---
 rtl/axi_single_beat_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_axi_single_beat_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_single_beat_bridge.sv
// axi_single_beat_bridge
// Turns the uncache unit's one-word req/accept/fin handshake into a single-beat
// AXI4 read or write. One transaction is in flight at a time; every
// handshake-related output comes straight from a register.

module axi_single_beat_bridge #(
    parameter int            ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd0
) (
    input  logic            clk,
    input  logic            rst,
    // requester side
    input  logic            req_en,
    input  logic [3:0]      req_wsel,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            accept,
    output logic            fin,
    output logic [31:0]     rdata,
    output logic            resp_err,
    // AR channel
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    // R channel
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata_axi,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    // AW channel
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    // W channel
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    // B channel
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_accept;
    logic        r_fin;
    logic        r_resp_err;
    logic [31:0] r_rdata;
    logic [31:0] r_araddr;
    logic        r_arvalid;
    logic        r_rready;
    logic [31:0] r_awaddr;
    logic        r_awvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_wvalid;
    logic        r_bready;

    // A write channel counts as finished once its valid has dropped or its
    // handshake completes in the current cycle, so AW and W may end in any order.
    logic w_aw_ok;
    logic w_w_ok;
    logic w_unused;

    assign w_aw_ok  = (!r_awvalid) || awready;
    assign w_w_ok   = (!r_wvalid) || wready;
    // ID and last fields are deliberately not checked on responses.
    assign w_unused = ^{rid, rlast, bid};

    // Main control FSM; owns every registered output of the bridge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_accept   <= 1'b0;
            r_fin      <= 1'b0;
            r_resp_err <= 1'b0;
            r_rdata    <= 32'd0;
            r_araddr   <= 32'd0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awaddr   <= 32'd0;
            r_awvalid  <= 1'b0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_en) begin
                        r_accept <= 1'b1;
                        if (req_wsel == 4'b0000) begin
                            r_araddr  <= req_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end else begin
                            r_awaddr  <= req_addr;
                            r_wdata   <= req_wdata;
                            r_wstrb   <= req_wsel;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end else begin
                        r_state <= ST_RD_ADDR;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid && r_rready) begin
                        r_rdata    <= rdata_axi;
                        r_rready   <= 1'b0;
                        r_fin      <= 1'b1;
                        r_resp_err <= (rresp != 2'b00);
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_WR_REQ: begin
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                    end else begin
                        r_awvalid <= r_awvalid;
                    end
                    if (r_wvalid && wready) begin
                        r_wvalid <= 1'b0;
                    end else begin
                        r_wvalid <= r_wvalid;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end else begin
                        r_state <= ST_WR_REQ;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid && r_bready) begin
                        r_bready   <= 1'b0;
                        r_fin      <= 1'b1;
                        r_resp_err <= (bresp != 2'b00);
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_WR_RESP;
                    end
                end
                ST_DONE: begin
                    r_fin      <= 1'b0;
                    r_resp_err <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign accept   = r_accept;
    assign fin      = r_fin;
    assign rdata    = r_rdata;
    assign resp_err = r_resp_err;

    assign arid     = AXI_ID;
    assign araddr   = r_araddr;
    assign arlen    = 8'd0;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign arvalid  = r_arvalid;
    assign rready   = r_rready;

    assign awid     = AXI_ID;
    assign awaddr   = r_awaddr;
    assign awlen    = 8'd0;
    assign awsize   = 3'b010;
    assign awburst  = 2'b01;
    assign awvalid  = r_awvalid;

    assign wdata    = r_wdata;
    assign wstrb    = r_wstrb;
    assign wlast    = 1'b1;
    assign wvalid   = r_wvalid;
    assign bready   = r_bready;

endmodule

// File: tb/tb_axi_single_beat_bridge.sv
// Self-checking bench for axi_single_beat_bridge: a vector table drives reads
// and writes through a delay-programmable AXI slave; a scoreboard queue holds
// expected fin results pushed on accept and popped on fin.

module tb_axi_single_beat_bridge;

    logic        clk;
    logic        rst;
    logic        req_en;
    logic [3:0]  req_wsel;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        accept;
    logic        fin;
    logic [31:0] rdata;
    logic        resp_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_single_beat_bridge dut (
        .clk(clk), .rst(rst),
        .req_en(req_en), .req_wsel(req_wsel), .req_addr(req_addr), .req_wdata(req_wdata),
        .accept(accept), .fin(fin), .rdata(rdata), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wsel;
        logic [31:0] addr;
        logic [31:0] wdat;
        int          ar_dly;
        int          r_dly;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic [1:0]  resp;
        logic [31:0] slave_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs [7];
    exp_t sb_q [$];
    int   n_checks;
    int   n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop at fin: compare rdata and resp_err against the entry pushed at accept.
    task automatic pop_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_rdata"}, rdata, e.rdata);
            check({name, "_resp_err"}, {31'd0, resp_err}, {31'd0, e.err});
        end
    endtask

    // Present a request and wait (bounded) for accept; it must come after exactly one edge.
    task automatic do_accept(input vec_t v);
        int n;
        req_en    = 1'b1;
        req_wsel  = v.wsel;
        req_addr  = v.addr;
        req_wdata = v.wdat;
        n = 0;
        while (n < 10) begin
            tick();
            n++;
            if (accept) break;
        end
        req_en = 1'b0;
        check("accept_latency", n, 1);
        sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    endtask

    task automatic run_read(input vec_t v);
        do_accept(v);
        check("rd_start", {29'd0, arvalid, awvalid, wvalid}, {29'd0, 1'b1, 1'b0, 1'b0});
        check("rd_const", {8'd0, arlen, 5'd0, arsize, 6'd0, arburst}, {8'd0, 8'd0, 5'd0, 3'b010, 6'd0, 2'b01});
        for (int c = 0; c <= v.ar_dly; c++) begin
            arready = (c == v.ar_dly);
            tick();
            check("rd_araddr", araddr, v.addr);
            check("rd_ar_phase", {30'd0, arvalid, rready}, {30'd0, c < v.ar_dly, c == v.ar_dly});
        end
        arready = 1'b0;
        for (int c = 0; c <= v.r_dly; c++) begin
            rvalid    = (c == v.r_dly);
            rdata_axi = v.slave_rdata;
            rresp     = v.resp;
            tick();
            if (c < v.r_dly) begin
                check("rd_r_wait", {30'd0, rready, fin}, {30'd0, 1'b1, 1'b0});
            end else begin
                check("rd_fin", {30'd0, fin, rready}, {30'd0, 1'b1, 1'b0});
                pop_check("rd");
            end
        end
        rvalid    = 1'b0;
        rdata_axi = 32'hFFFF_FFFF;
        tick();
        check("rd_done", {29'd0, fin, resp_err, accept}, 32'd0);
        check("rd_hold", rdata, v.exp_rdata);
    endtask

    task automatic run_write(input vec_t v);
        int mx;
        int aw_hs;
        int w_hs;
        mx    = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
        aw_hs = 0;
        w_hs  = 0;
        do_accept(v);
        check("wr_start", {29'd0, arvalid, awvalid, wvalid}, {29'd0, 1'b0, 1'b1, 1'b1});
        check("wr_fields", awaddr ^ wdata, v.addr ^ v.wdat);
        check("wr_wdata", wdata, v.wdat);
        check("wr_wstrb", {28'd0, wstrb}, {28'd0, v.wsel});
        check("wr_const", {awlen, 5'd0, awsize, 6'd0, awburst, 7'd0, wlast}, {8'd0, 5'd0, 3'b010, 6'd0, 2'b01, 7'd0, 1'b1});
        for (int c = 0; c <= mx; c++) begin
            awready = (c >= v.aw_dly);
            wready  = (c >= v.w_dly);
            if (awvalid && awready) aw_hs++;
            if (wvalid && wready) w_hs++;
            tick();
            check("wr_awaddr", awaddr, v.addr);
            check("wr_phase", {29'd0, awvalid, wvalid, bready}, {29'd0, c < v.aw_dly, c < v.w_dly, c == mx});
        end
        awready = 1'b0;
        wready  = 1'b0;
        check("wr_hs_count", aw_hs * 16 + w_hs, 17);
        for (int c = 0; c <= v.b_dly; c++) begin
            bvalid = (c == v.b_dly);
            bresp  = v.resp;
            tick();
            if (c < v.b_dly) begin
                check("wr_b_wait", {30'd0, bready, fin}, {30'd0, 1'b1, 1'b0});
            end else begin
                check("wr_fin", {30'd0, fin, bready}, {30'd0, 1'b1, 1'b0});
                pop_check("wr");
            end
        end
        bvalid = 1'b0;
        tick();
        check("wr_done", {29'd0, fin, resp_err, accept}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.wsel == 4'b0000) begin
            run_read(v);
        end else begin
            run_write(v);
        end
    endtask

    task automatic check_all_idle(input string name);
        check(name, {24'd0, arvalid, rready, awvalid, wvalid, bready, accept, fin, resp_err}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_en    = 1'b0;
        req_wsel  = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        arready   = 1'b0;
        rid       = 4'd0;
        rdata_axi = 32'd0;
        rresp     = 2'd0;
        rlast     = 1'b1;
        rvalid    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bid       = 4'd0;
        bresp     = 2'd0;
        bvalid    = 1'b0;

        //           wsel     addr          wdata         ar r aw w b resp   slave_rdata   exp_rdata     err
        vecs[0] = '{4'b0000, 32'h0000_1000, 32'h0,        0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{4'b0000, 32'h0000_2004, 32'h0,        3, 2, 0, 0, 0, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
        vecs[2] = '{4'b0011, 32'h0000_3008, 32'h12345678, 0, 0, 0, 2, 1, 2'b00, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[3] = '{4'b1100, 32'h0000_400C, 32'hA5A5_0F0F, 0, 0, 2, 0, 0, 2'b00, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[4] = '{4'b1111, 32'h0000_5010, 32'h7777_8888, 0, 0, 1, 1, 0, 2'b00, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[5] = '{4'b0000, 32'h0000_6014, 32'h0,        1, 0, 0, 0, 0, 2'b10, 32'h0BADF00D, 32'h0BADF00D, 1'b1};
        vecs[6] = '{4'b0101, 32'h0000_7018, 32'h0101_0202, 0, 0, 0, 0, 2, 2'b11, 32'h0,        32'h0BADF00D, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        check_all_idle("reset_ctrl");
        check("reset_araddr", araddr, 32'd0);
        check("reset_awaddr", awaddr, 32'd0);
        check("reset_wdata", wdata, 32'd0);
        check("reset_wstrb", {28'd0, wstrb}, 32'd0);
        check("reset_rdata", rdata, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while waiting for R data.
        do_accept(vecs[1]);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rst_rd_pre", {31'd0, rready}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_idle("rst_rd_data");
        check("rst_rd_rdata", rdata, 32'd0);
        sb_q.delete();
        run_vec(vecs[0]);

        // Reset while AW/W are still pending.
        do_accept(vecs[2]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_idle("rst_wr_req");
        sb_q.delete();
        run_vec(vecs[5]);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
